// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, the queued
// command record and the trap rule for commands that must not reach the ALU.
package alu_op_sequencer_pkg;

    localparam int ALU_W = 8;
    localparam logic [7:0] ALU_ERR_RESULT = 8'hFF;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        MOD = 3'd4
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    // op is kept raw so that illegal encodings survive queueing and can be trapped.
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
    } alu_cmd_t;

    function automatic logic is_trap(input alu_cmd_t cmd);
        return (cmd.op > 3'(MOD)) ||
               (((cmd.op == 3'(DIV)) || (cmd.op == 3'(MOD))) && (cmd.b == '0));
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead FIFO of ALU commands; the head entry is visible on
// rd_data whenever the FIFO is not empty.
module alu_cmd_fifo
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  alu_cmd_t               wr_data,
    input  logic                   pop,
    output alu_cmd_t               rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command stage in front of simple_alu: queues commands, issues one at a time,
// waits out the ALU latency and returns results in order, trapping bad commands.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1,
    parameter int W           = ALU_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [2:0]             in_op,
    output logic                   alu_start,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output logic [2:0]             alu_mode,
    input  logic [W-1:0]           alu_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_result,
    output logic [2:0]             out_op,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output seq_state_t             state
);

    // Valid/ready: a transfer happens on a rising clock edge where both valid
    // and ready are high; valid never waits on ready, and payload is stable
    // while valid is high and the transfer has not yet happened.

    localparam int CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

    seq_state_t     state_q;
    seq_state_t     state_d;
    logic [CNT_W-1:0] wait_cnt;
    alu_cmd_t       head;
    alu_cmd_t       wr_cmd;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           push;
    logic           head_trap;

    assign in_ready  = !reset && !fifo_full;
    assign push      = in_valid && in_ready;
    assign wr_cmd    = '{a: ALU_W'(in_a), b: ALU_W'(in_b), op: in_op};
    assign head_trap = is_trap(head);
    assign state     = state_q;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        alu_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_trap ? HOLD : ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (wait_cnt == CNT_W'(1)) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= '0;
            out_result <= '0;
            out_op     <= '0;
            out_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                alu_a    <= W'(head.a);
                alu_b    <= W'(head.b);
                alu_mode <= head.op;
                if (head_trap) begin
                    out_result <= W'(ALU_ERR_RESULT);
                    out_err    <= 1'b1;
                    out_op     <= head.op;
                end
            end
            if (state_q == ISSUE) wait_cnt <= CNT_W'(ALU_LATENCY);
            // alu_c is only trusted here: the ALU register itself has no reset.
            if (state_q == WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
                if (wait_cnt == CNT_W'(1)) begin
                    out_result <= alu_c;
                    out_err    <= 1'b0;
                    out_op     <= alu_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and an in-order
// transaction scoreboard checked every cycle.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [2:0]       in_op = '0;
    logic             alu_start;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_mode;
    logic [W-1:0]     alu_c;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_result;
    logic [2:0]       out_op;
    logic             out_err;
    logic [$clog2(DEPTH):0] fifo_count;
    seq_state_t       dbg_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int acc_cnt = 0;
    logic prev_start = 1'b0;

    logic [11:0] exp_q[$];
    logic [18:0] cmd_q[$];
    logic [11:0] got_q[$];

    always #5 clock = ~clock;

    alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(1), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_c      (alu_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_err    (out_err),
        .fifo_count (fifo_count),
        .state      (dbg_state)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return p[7:0];
            3'd3: return (b == 0) ? 8'hFF : a / b;
            3'd4: return (b == 0) ? 8'hFF : a % b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [11:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        if (op > 3'd4 || ((op == 3'd3 || op == 3'd4) && b == 0))
            return {op, 1'b1, 8'hFF};
        return {op, 1'b0, alu_fn(a, b, op)};
    endfunction

    // Registered ALU, captured on the start pulse, no reset.
    always @(posedge clock) begin
        if (alu_start) alu_c <= alu_fn(alu_a, alu_b, alu_mode);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            cmd_q.delete();
            prev_start = 1'b0;
        end else begin
            int occ;
            occ = exp_q.size();
            check("occupancy", 32'((occ == int'(fifo_count)) || (occ == int'(fifo_count) + 1)), 1);
            if (occ < DEPTH)  check("ready_when_room", 32'(in_ready), 1);
            if (occ > DEPTH)  check("ready_when_full", 32'(in_ready), 0);
            if (alu_start) begin
                start_cnt++;
                check("start_single_cycle", 32'(prev_start), 0);
                if (cmd_q.size() == 0) check("start_unexpected", 1, 0);
                else check("alu_operands", 32'({alu_a, alu_b, alu_mode}), 32'(cmd_q[0]));
            end
            prev_start = alu_start;
            if (out_valid) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else check("result", 32'({out_op, out_err, out_result}), 32'(exp_q[0]));
                if (out_ready) begin
                    got_q.push_back({out_op, out_err, out_result});
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        void'(cmd_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                exp_q.push_back(ref_res(in_a, in_b, in_op));
                cmd_q.push_back({in_a, in_b, in_op});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int n = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clock);
            n++;
        end
        if (n >= 500) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Starts at posedge+1 right after an accept; counts edges until out_valid.
    task automatic edges_to_valid(output int edges);
        edges = 0;
        @(negedge clock);
        while (!out_valid && edges < 50) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clock);
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!out_valid) check("wait_valid_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int s0;
        int base;
        int a0;

        @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_ctrl", 32'({alu_start, out_valid, out_err}), 0);
        check("rst_data", 32'({alu_a, alu_b, alu_mode, out_result, out_op}), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // ADD with latency measurement
        out_ready = 1'b1;
        s0 = start_cnt;
        send(8'd20, 8'd22, 3'd0);
        edges_to_valid(edges);
        check("add_latency", 32'(edges), 3);
        check("add_value", 32'({out_op, out_err, out_result}), 32'({3'd0, 1'b0, 8'd42}));
        drain();
        check("add_starts", 32'(start_cnt - s0), 1);

        // MUL then SUB, in order
        s0 = start_cnt;
        base = got_q.size();
        send(8'd20, 8'd13, 3'd2);
        send(8'd5, 8'd9, 3'd1);
        drain();
        check("mul_low_bits", 32'(got_q[base]), 32'({3'd2, 1'b0, 8'h04}));
        check("sub_wrap", 32'(got_q[base+1]), 32'({3'd1, 1'b0, 8'hFC}));
        check("mul_sub_starts", 32'(start_cnt - s0), 2);

        // Trapped commands never reach the ALU
        s0 = start_cnt;
        base = got_q.size();
        send(8'd7, 8'd0, 3'd3);
        edges_to_valid(edges);
        check("trap_latency", 32'(edges), 1);
        drain();
        send(8'd9, 8'd0, 3'd4);
        send(8'd1, 8'd2, 3'd7);
        drain();
        check("div_zero", 32'(got_q[base]), 32'({3'd3, 1'b1, 8'hFF}));
        check("mod_zero", 32'(got_q[base+1]), 32'({3'd4, 1'b1, 8'hFF}));
        check("illegal_op", 32'(got_q[base+2]), 32'({3'd7, 1'b1, 8'hFF}));
        check("trap_starts", 32'(start_cnt - s0), 0);

        // Capacity: DEPTH queued plus one held
        out_ready = 1'b0;
        base = got_q.size();
        a0 = acc_cnt;
        for (int i = 1; i <= 5; i++) send(8'(i), 8'(i), 3'd0);
        @(negedge clock);
        check("cap_ready_low", 32'(in_ready), 0);
        check("cap_count_full", 32'(fifo_count), DEPTH);
        @(posedge clock);
        #1;
        fork
            send(8'd6, 8'd6, 3'd0);
        join_none
        repeat (3) @(posedge clock);
        #1;
        check("cap_sixth_blocked", 32'(acc_cnt - a0), 5);
        out_ready = 1'b1;
        wait fork;
        drain();
        for (int i = 0; i < 6; i++)
            check("cap_order", 32'(got_q[base+i]), 32'({3'd0, 1'b0, 8'(2*(i+1))}));

        // Push and pop on the same edge
        out_ready = 1'b0;
        base = got_q.size();
        send(8'd1, 8'd2, 3'd0);
        wait_valid();
        send(8'd2, 8'd2, 3'd0);
        send(8'd3, 8'd3, 3'd0);
        send(8'd4, 8'd4, 3'd0);
        @(negedge clock);
        check("pp_count_hold", 32'(fifo_count), 3);
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_a = 8'd9; in_b = 8'd9; in_op = 3'd0; in_valid = 1'b1;
        @(negedge clock);
        check("pp_state_idle", 32'(dbg_state), 32'(IDLE));
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("pp_count_same", 32'(fifo_count), 3);
        check("pp_state_issue", 32'(dbg_state), 32'(ISSUE));
        @(posedge clock);
        #1 out_ready = 1'b1;
        drain();
        check("pp_r0", 32'(got_q[base]),   32'({3'd0, 1'b0, 8'd3}));
        check("pp_r1", 32'(got_q[base+1]), 32'({3'd0, 1'b0, 8'd4}));
        check("pp_r4", 32'(got_q[base+4]), 32'({3'd0, 1'b0, 8'd18}));
        check("pp_total", 32'(got_q.size() - base), 5);

        // Reset during WAIT discards everything
        out_ready = 1'b0;
        send(8'd200, 8'd10, 3'd3);
        send(8'd1, 8'd1, 3'd0);
        send(8'd2, 8'd2, 3'd0);
        check("mid_state_wait", 32'(dbg_state), 32'(WAIT));
        check("mid_count", 32'(fifo_count), 2);
        reset = 1'b1;
        #1;
        check("mid_rst_ctrl", 32'({in_ready, alu_start, out_valid, out_err}), 0);
        check("mid_rst_data", 32'({alu_a, alu_b, alu_mode, out_result, out_op}), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        base = got_q.size();
        repeat (10) @(posedge clock);
        #1;
        check("no_stale_result", 32'(got_q.size() - base), 0);
        send(8'd3, 8'd4, 3'd0);
        drain();
        check("post_reset_add", 32'(got_q[base]), 32'({3'd0, 1'b0, 8'd7}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream command stage for simple_alu.
- Accepts (a, b, opcode) commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU, holding operands stable, and waits out the ALU's registered latency.
- Captures the ALU's c output and returns it with the opcode over a valid/ready result interface. DIV/MOD by zero and illegal opcodes are trapped locally and never issued to the ALU.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- ALU_LATENCY, 1: cycles from the ALU-capturing edge until c is sampled; 1 matches simple_alu.
- W, 8: operand/result width.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid&in_ready at posedge.
- in_a  in  W  operand a.
- in_b  in  W  operand b.
- in_op  in  3  opcode (tb_pkg opcode).
- alu_start  out  1  one-cycle issue pulse to ALU start.
- alu_a  out  W  to ALU a.
- alu_b  out  W  to ALU b.
- alu_mode  out  3  to ALU mode_select.
- alu_c  in  W  from ALU c.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&out_ready at posedge.
- out_result  out  W  result.
- out_op  out  3  opcode of this result.
- out_err  out  1  divide/mod by zero or illegal opcode.
- fifo_count  out  $clog2(DEPTH)+1  entries queued.

Behaviour:
- Interface decision (fixed): one clock; reset is asynchronous and active-high.
- Reset values: in_ready=0 while reset is high; all of alu_start, alu_a, alu_b, alu_mode, out_valid, out_result, out_op, out_err, fifo_count = 0; FIFO emptied; state=IDLE.
- Reset mid-operation: any in-flight or queued command is discarded with no output.
- in_ready = !full when not in reset. Push on in_valid&in_ready.
- When full, in_valid is ignored and no data changes. Push and pop on the same edge are allowed; fifo_count is then unchanged.
- Ordering: results are returned strictly in command order.
- FSM states are IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If the FIFO is empty, stay in IDLE.
  - Otherwise pop the head entry and register alu_a/alu_b/alu_mode.
  - If op∈{DIV,MOD} with b==0, or op>MOD: load out_result=8'hFF, out_err=1, out_op=op, go to HOLD. The ALU is not touched.
  - Otherwise go to ISSUE.
- ISSUE: alu_start=1 for exactly this cycle; load wait counter=ALU_LATENCY; go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle it reads 1, capture alu_c into out_result with out_err=0, out_op=alu_mode, and go to HOLD.
- Operand stability: alu_a/alu_b/alu_mode hold stable from IDLE-pop through the end of WAIT, and through HOLD.
- HOLD: out_valid=1, with out_result, out_op and out_err stable. On out_ready go to IDLE and drop out_valid on the next cycle. No back-to-back skip: IDLE always takes one cycle.
- Latency, ALU_LATENCY=1, from the accepting edge E0 with an empty pipeline:
  - Normal command: out_valid rises after E0+3 edges.
  - Trapped command: out_valid rises after E0+1 edge.
- Arithmetic: the sequencer never modifies alu_c. MUL returns the low W bits; SUB wraps modulo 2^W.
- ALU output qualification: the ALU register has no reset, so alu_c is never sampled outside WAIT.
- Capacity: DEPTH queued entries plus one held command.

Decomposition:
- tb_pkg: reuse the existing opcode type, encoded ADD=0, SUB=1, MUL=2, DIV=3, MOD=4.
- tb_pkg additions:
  - seq_state_t {IDLE, ISSUE, WAIT, HOLD}.
  - localparam ALU_ERR_RESULT = 8'hFF.
  - a packed struct alu_cmd_t {a, b, op} (19 bits).
- One sub-module: alu_cmd_fifo, a synchronous FIFO of alu_cmd_t with DEPTH, full/empty/count, and asynchronous active-high reset.

Test Plan:
1. ADD a=20, b=22, out_ready=1 -> alu_start pulses once; out_result=42, out_op=ADD, out_err=0; out_valid rises 3 edges after accept.
2. MUL a=20, b=13, then SUB a=5, b=9 -> results 8'h04 then 8'hFC, in order; alu_start pulses twice.
3. DIV a=7, b=0, then MOD a=9, b=0, then opcode 7 -> each returns 8'hFF with out_err=1, one edge after pop; alu_start never asserts.
4. Hold out_ready=0 and push ADD 1+1 .. 6+6 back-to-back -> 5 accepted; in_ready low after the 5th until one result is consumed. Release out_ready -> outputs 2, 4, 6, 8, 10, then the 6th command (12) is accepted.
5. With fifo_count=DEPTH-1 during HOLD, push and consume on the same edge -> fifo_count unchanged, no entry lost or duplicated.
6. Assert reset in WAIT for DIV 200/10 with 2 entries queued -> all outputs 0, fifo_count=0. After release, no stale result appears; a new ADD 3+4 returns 7.
